// File: rtl/otter_pkg.sv
// Shared OTTER types: opcodes, the NOP encoding and the fetch-queue entry.
package otter_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_t;

  localparam logic [31:0] OTTER_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/otter_sync_fifo.sv
// Generic synchronous FIFO with flush; head is read straight from registered storage.
module otter_sync_fifo #(
  parameter type T     = logic [63:0],
  parameter int  DEPTH = 4
) (
  input  logic                       gclk,
  input  logic                       grst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  T                           din,
  output T                           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      if (do_push & ~do_pop)      count <= count + 1'b1;
      else if (do_pop & ~do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge gclk) begin
    if (do_push & ~flush) mem[wr_ptr] <= din;
  end

  overflow_chk: assert property (@(posedge gclk) disable iff (!grst_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/otter_fetch_queue.sv
// OTTER fetch front end: owns the fetch PC, issues reads with queue credit, buffers {pc, ir} for decode.
module otter_fetch_queue
  import otter_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          ADDR_W   = 14
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       REDIRECT,
  input  logic [31:0]                REDIRECT_PC,
  output logic                       IMEM_RDEN,
  output logic [ADDR_W-1:0]          IMEM_ADDR,
  input  logic [31:0]                IMEM_DOUT,
  output logic                       DE_VALID,
  input  logic                       DE_READY,
  output logic [31:0]                DE_IR,
  output logic [31:0]                DE_PC,
  output logic [$clog2(DEPTH+1)-1:0] QUEUE_COUNT
);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]  fetch_pc, inflight_pc;
  logic         inflight, push, pop, empty;
  logic [CW:0]  occ;
  fetch_entry_t head, din;

  // Credit counts the in-flight read but never the same-cycle pop, so
  // DE_READY has no combinational path to IMEM_RDEN.
  assign occ       = {1'b0, QUEUE_COUNT} + (CW+1)'(inflight);
  assign IMEM_RDEN = RESET_N & ~REDIRECT & (occ < (CW+1)'(DEPTH));
  assign IMEM_ADDR = fetch_pc[ADDR_W+1:2];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (REDIRECT) begin
      fetch_pc <= word_align(REDIRECT_PC);
      inflight <= 1'b0;
    end else begin
      inflight <= IMEM_RDEN;
      if (IMEM_RDEN) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
    end
  end

  // A redirect drops the returning data and any pop in the same cycle.
  assign push   = inflight & ~REDIRECT;
  assign pop    = DE_READY & ~empty & ~REDIRECT;
  assign din.pc = inflight_pc;
  assign din.ir = IMEM_DOUT;

  otter_sync_fifo #(.T(fetch_entry_t), .DEPTH(DEPTH)) u_fifo (
    .gclk   (CLK),
    .grst_n (RESET_N),
    .push   (push),
    .pop    (pop),
    .flush  (REDIRECT),
    .din    (din),
    .head   (head),
    .count  (QUEUE_COUNT),
    .empty  (empty)
  );

  assign DE_VALID = ~empty;
  assign DE_IR    = empty ? OTTER_NOP : head.ir;
  assign DE_PC    = empty ? 32'h0     : head.pc;

endmodule

// File: tb/tb_otter_fetch_queue.sv
// Scoreboard bench for otter_fetch_queue: program-order model of {pc, ir} plus directed timing checks.
module tb_otter_fetch_queue;
  import otter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, redirect, de_ready;
  logic [31:0] redirect_pc;

  logic        rden, de_valid;
  logic [13:0] addr;
  logic [31:0] dout = '0, de_ir, de_pc;
  logic [2:0]  count;

  logic        rden3, de_valid3, rden2, de_valid2;
  logic [13:0] addr3, addr2;
  logic [31:0] dout3 = '0, dout2 = '0, de_ir3, de_pc3, de_ir2, de_pc2;
  logic [1:0]  count3, count2;

  fetch_entry_t exp_q[$];
  int n_cmp = 0, n_bad = 0, n_acc = 0;
  int acc3 = 0, acc2 = 0;
  logic [31:0] exp3 = '0, exp2 = '0;

  always #5 clk = ~clk;

  otter_fetch_queue #(.DEPTH(4)) dut (
    .CLK(clk), .RESET_N(rst_n), .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
    .IMEM_RDEN(rden), .IMEM_ADDR(addr), .IMEM_DOUT(dout),
    .DE_VALID(de_valid), .DE_READY(de_ready), .DE_IR(de_ir), .DE_PC(de_pc),
    .QUEUE_COUNT(count));

  otter_fetch_queue #(.DEPTH(3)) dut3 (
    .CLK(clk), .RESET_N(rst_n), .REDIRECT(1'b0), .REDIRECT_PC(32'h0),
    .IMEM_RDEN(rden3), .IMEM_ADDR(addr3), .IMEM_DOUT(dout3),
    .DE_VALID(de_valid3), .DE_READY(1'b1), .DE_IR(de_ir3), .DE_PC(de_pc3),
    .QUEUE_COUNT(count3));

  otter_fetch_queue #(.DEPTH(2)) dut2 (
    .CLK(clk), .RESET_N(rst_n), .REDIRECT(1'b0), .REDIRECT_PC(32'h0),
    .IMEM_RDEN(rden2), .IMEM_ADDR(addr2), .IMEM_DOUT(dout2),
    .DE_VALID(de_valid2), .DE_READY(1'b1), .DE_IR(de_ir2), .DE_PC(de_pc2),
    .QUEUE_COUNT(count2));

  // Program image: two fixed words at 0/4, then an addi whose immediate tags the address.
  function automatic logic [31:0] instr(input logic [13:0] wa);
    case (wa)
      14'd0:   return 32'h0050_0093;
      14'd1:   return 32'h0010_0113;
      default: return {wa[11:0], 5'd2, 3'b000, 5'd3, 7'h13};
    endcase
  endfunction

  always @(posedge clk) begin
    if (rden)  dout  <= instr(addr);
    if (rden3) dout3 <= instr(addr3);
    if (rden2) dout2 <= instr(addr2);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_restart(input logic [31:0] pc);
    fetch_entry_t e;
    logic [31:0]  p;
    p = {pc[31:2], 2'b00};
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      e.pc = p;
      e.ir = instr(p[15:2]);
      exp_q.push_back(e);
      p = p + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumer side: every accepted head must be the next entry in program order.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (!rst_n) begin
      exp3 = '0;
      exp2 = '0;
    end else begin
      if (!redirect && de_valid && de_ready) begin
        if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("de_pc", de_pc, e.pc);
          chk("de_ir", de_ir, e.ir);
        end
        n_acc++;
      end
      if (de_valid3) begin
        chk("d3_pc", de_pc3, exp3);
        chk("d3_ir", de_ir3, instr(exp3[15:2]));
        exp3 = exp3 + 32'd4;
        acc3++;
      end
      if (de_valid2) begin
        chk("d2_pc", de_pc2, exp2);
        chk("d2_ir", de_ir2, instr(exp2[15:2]));
        exp2 = exp2 + 32'd4;
        acc2++;
      end
      chk("d3_cnt_max", 32'(count3 <= 2'd3), 32'd1);
    end
  end

  initial begin
    int a3, a2;
    bit ok;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; de_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_rden",  32'(rden),     32'd0);
    chk("rst_valid", 32'(de_valid), 32'd0);
    chk("rst_ir",    de_ir,         OTTER_NOP);
    chk("rst_pc",    de_pc,         32'd0);
    chk("rst_count", 32'(count),    32'd0);

    // Release reset: one read per cycle, first instruction visible two cycles later.
    tick();
    rst_n = 1'b1; de_ready = 1'b1; sb_restart(32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t1_addr",  32'(addr),     32'(c));
      chk("t1_rden",  32'(rden),     32'd1);
      chk("t1_valid", 32'(de_valid), 32'(c >= 2));
      if (c == 2) begin
        chk("t1_pc0", de_pc, 32'h0);
        chk("t1_ir0", de_ir, 32'h0050_0093);
      end
      if (c == 3) begin
        chk("t1_pc4", de_pc, 32'h4);
        chk("t1_ir4", de_ir, 32'h0010_0113);
      end
      tick();
    end

    // Throughput over 21 steady cycles: DEPTH=3 sustains 1/cycle, DEPTH=2 settles to 2 per 3.
    a3 = acc3; a2 = acc2;
    repeat (21) tick();
    chk("tp_d3", 32'(acc3 - a3), 32'd21);
    chk("tp_d2", 32'(acc2 - a2), 32'd14);

    // Backpressure: queue saturates, issue stops, then drains in order.
    de_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("t2_cnt_max", 32'(count <= 3'd4), 32'd1);
      if (count == 3'd4) chk("t2_rden_full", 32'(rden), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("t2_count", 32'(count), 32'd4);
    chk("t2_rden",  32'(rden),  32'd0);
    chk("t2_valid", 32'(de_valid), 32'd1);
    tick();
    de_ready = 1'b1;
    repeat (8) tick();

    // Redirect with queue partly full and a read in flight.
    de_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h10; sb_restart(32'h10);
    tick();
    redirect = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (count == 3'd2) ok = 1'b1;
      tick();
    end
    chk("t3_fill", 32'(ok), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h40; sb_restart(32'h40);
    @(negedge clk);
    chk("t3_rden_redir", 32'(rden), 32'd0);
    chk("t3_pre_count",  32'(count), 32'd3);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("t3_valid0", 32'(de_valid), 32'd0);
    chk("t3_count0", 32'(count),    32'd0);
    chk("t3_addr",   32'(addr),     32'h10);
    chk("t3_rden",   32'(rden),     32'd1);
    tick();
    @(negedge clk);
    chk("t3_valid1", 32'(de_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("t3_valid2", 32'(de_valid), 32'd1);
    chk("t3_pc",     de_pc,         32'h40);
    chk("t3_ir",     de_ir,         instr(14'h10));
    tick();
    de_ready = 1'b1;
    repeat (6) tick();

    // Misaligned redirect target while decode is accepting.
    redirect = 1'b1; redirect_pc = 32'h43; sb_restart(32'h43);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("t4_addr",  32'(addr),     32'h10);
    chk("t4_valid", 32'(de_valid), 32'd0);
    tick();
    repeat (6) tick();

    // PC wraps past 2^32; then back-to-back redirects where the last one wins.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; sb_restart(32'hFFFF_FFF8);
    tick();
    redirect = 1'b0;
    repeat (8) tick();
    redirect = 1'b1; redirect_pc = 32'h100; sb_restart(32'h100);
    tick();
    redirect_pc = 32'h200; sb_restart(32'h200);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("b2b_addr", 32'(addr), 32'h80);
    tick();
    repeat (6) tick();

    // Random backpressure and redirects, checked by the scoreboard.
    for (int i = 0; i < 300; i++) begin
      de_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        redirect = 1'b1; redirect_pc = $urandom; sb_restart(redirect_pc);
      end else redirect = 1'b0;
      tick();
    end
    redirect = 1'b0; de_ready = 1'b0;

    // Asynchronous reset mid-stream with three entries queued.
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      if (count == 3'd3) ok = 1'b1;
      else tick();
    end
    chk("t6_fill", 32'(ok), 32'd1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_valid", 32'(de_valid), 32'd0);
    chk("t6_count", 32'(count),    32'd0);
    chk("t6_rden",  32'(rden),     32'd0);
    chk("t6_ir",    de_ir,         OTTER_NOP);
    tick();
    tick();
    rst_n = 1'b1; de_ready = 1'b1; sb_restart(32'h0);
    @(negedge clk);
    chk("t6_addr", 32'(addr), 32'h0);
    chk("t6_rden_rel", 32'(rden), 32'd1);
    tick();
    repeat (10) tick();
    chk("accepted", 32'(n_acc > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
